// File: rtl/pr_region_sequencer_if.sv
// Command channel between the host control path and pr_region_sequencer.
// The host drives the master side; the sequencer implements the slave side.
interface pr_region_sequencer_if #(
    parameter int REGION_W = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [REGION_W-1:0] cmd_region;
    logic [1:0]          cmd_op;
    logic                cmd_err;

    modport master (
        output cmd_valid, cmd_region, cmd_op,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_region, cmd_op,
        output cmd_ready, cmd_err
    );
endinterface

// File: rtl/pr_region_sequencer.sv
// Per-region freeze -> timed reset -> unfreeze handshake sequencer for PR regions.
// Define PR_SEQ_TIMEOUT_EN to add a per-region handshake timeout that traps to ERROR.
module pr_region_sequencer #(
    parameter int NUM_REGIONS    = 3,
    parameter int REGION_W       = 2,
    parameter int RESET_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset_n,
    pr_region_sequencer_if.slave     cmd,
    output logic [NUM_REGIONS-1:0]   freeze_req,
    input  logic [NUM_REGIONS-1:0]   freeze_status,
    output logic [NUM_REGIONS-1:0]   unfreeze_req,
    input  logic [NUM_REGIONS-1:0]   unfreeze_status,
    output logic [NUM_REGIONS-1:0]   region_reset,
    input  logic [2*NUM_REGIONS-1:0] illegal_req,
    output logic [3*NUM_REGIONS-1:0] region_state,
    output logic [NUM_REGIONS-1:0]   region_err,
    output logic                     done_irq
);

    typedef enum logic [2:0] {
        ST_RUNNING      = 3'd0,
        ST_FREEZE_REQ   = 3'd1,
        ST_FROZEN       = 3'd2,
        ST_RESET        = 3'd3,
        ST_UNFREEZE_REQ = 3'd4,
        ST_ERROR        = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_FREEZE   = 2'b00,
        OP_UNFREEZE = 2'b01,
        OP_CLEAR    = 2'b10,
        OP_RSVD     = 2'b11
    } op_e;

    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_CYCLES - 1);

    if (NUM_REGIONS < 1 || NUM_REGIONS > 16 || (2 ** REGION_W) < NUM_REGIONS ||
        RESET_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("pr_region_sequencer: illegal parameter combination");
    end

    state_e           state_q   [NUM_REGIONS];
    state_e           state_d   [NUM_REGIONS];
    logic [RST_W-1:0] rst_cnt_q [NUM_REGIONS];
    logic [RST_W-1:0] rst_cnt_d [NUM_REGIONS];

    logic                   cmd_fire;
    logic                   cmd_in_range;
    logic                   cmd_ready_c;
    logic [NUM_REGIONS-1:0] cmd_hit;
    logic [NUM_REGIONS-1:0] tmo_hit;
    logic [NUM_REGIONS-1:0] err_set;
    logic [NUM_REGIONS-1:0] err_clr;
    logic                   cmd_bad;
    logic                   done_set;
    logic                   done_clr;
    logic                   cmd_err_q;

    assign cmd_in_range = int'(cmd.cmd_region) < NUM_REGIONS;
    assign cmd_fire     = cmd.cmd_valid && cmd_ready_c;
    assign cmd.cmd_ready = cmd_ready_c;
    assign cmd.cmd_err   = cmd_err_q;

    // Busy regions stall the channel; an out-of-range index is accepted so it can be flagged.
    always_comb begin
        cmd_ready_c = 1'b1;
        cmd_hit     = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (int'(cmd.cmd_region) == r) begin
                cmd_hit[r] = cmd.cmd_valid;
                if (state_q[r] == ST_FREEZE_REQ || state_q[r] == ST_RESET ||
                    state_q[r] == ST_UNFREEZE_REQ) begin
                    cmd_ready_c = 1'b0;
                end
            end
        end
        cmd_hit = cmd_hit & {NUM_REGIONS{cmd_ready_c}};
    end

`ifdef PR_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q [NUM_REGIONS];

    // Counter is zero on the first cycle of a handshake state, so it hits after TIMEOUT_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGIONS; r++) tmo_cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                if ((state_q[r] == ST_FREEZE_REQ || state_q[r] == ST_UNFREEZE_REQ) &&
                    state_d[r] == state_q[r]) begin
                    tmo_cnt_q[r] <= tmo_cnt_q[r] + TMO_W'(1);
                end else begin
                    tmo_cnt_q[r] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGIONS; r++) tmo_hit[r] = (tmo_cnt_q[r] == TMO_LAST);
    end
`else
    assign tmo_hit = '0;
`endif

    // NOTE: every variable gets a default before any branch, otherwise always_comb infers latches.
    always_comb begin
        cmd_bad  = cmd_fire && !cmd_in_range;
        done_set = 1'b0;
        done_clr = 1'b0;
        err_set  = '0;
        err_clr  = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            state_d[r]   = state_q[r];
            rst_cnt_d[r] = rst_cnt_q[r];
            case (state_q[r])
                ST_RUNNING: begin
                    if (cmd_hit[r]) begin
                        if (cmd.cmd_op == OP_FREEZE) state_d[r] = ST_FREEZE_REQ;
                        else                         cmd_bad = 1'b1;
                    end
                end
                ST_FREEZE_REQ: begin
                    // Illegal request beats acknowledge; acknowledge beats timeout.
                    if (illegal_req[2*r +: 2] != 2'b00) begin
                        state_d[r] = ST_ERROR;
                        err_set[r] = 1'b1;
                    end else if (freeze_status[r]) begin
                        state_d[r] = ST_FROZEN;
                        done_set   = 1'b1;
                    end else if (tmo_hit[r]) begin
                        state_d[r] = ST_ERROR;
                        err_set[r] = 1'b1;
                    end
                end
                ST_FROZEN: begin
                    if (cmd_hit[r]) begin
                        if (cmd.cmd_op == OP_UNFREEZE) begin
                            state_d[r]   = ST_RESET;
                            rst_cnt_d[r] = RST_LOAD;
                        end else begin
                            cmd_bad = 1'b1;
                        end
                    end
                end
                ST_RESET: begin
                    if (rst_cnt_q[r] == '0) state_d[r] = ST_UNFREEZE_REQ;
                    else                    rst_cnt_d[r] = rst_cnt_q[r] - RST_W'(1);
                end
                ST_UNFREEZE_REQ: begin
                    if (illegal_req[2*r +: 2] != 2'b00) begin
                        state_d[r] = ST_ERROR;
                        err_set[r] = 1'b1;
                    end else if (unfreeze_status[r]) begin
                        state_d[r] = ST_RUNNING;
                        done_set   = 1'b1;
                    end else if (tmo_hit[r]) begin
                        state_d[r] = ST_ERROR;
                        err_set[r] = 1'b1;
                    end
                end
                ST_ERROR: begin
                    if (cmd_hit[r]) begin
                        if (cmd.cmd_op == OP_CLEAR) begin
                            state_d[r] = ST_FROZEN;
                            err_clr[r] = 1'b1;
                            done_clr   = 1'b1;
                        end else begin
                            cmd_bad = 1'b1;
                        end
                    end
                end
                default: state_d[r] = ST_RUNNING;
            endcase
        end
    end

    // NOTE: the per-region state array is control state, not storage, so every entry is reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                state_q[r]   <= ST_RUNNING;
                rst_cnt_q[r] <= '0;
            end
            freeze_req   <= '0;
            unfreeze_req <= '0;
            region_reset <= '0;
            region_err   <= '0;
            done_irq     <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            for (int r = 0; r < NUM_REGIONS; r++) begin
                state_q[r]      <= state_d[r];
                rst_cnt_q[r]    <= rst_cnt_d[r];
                // Decoding next state keeps the registered outputs aligned with state_q.
                freeze_req[r]   <= (state_d[r] == ST_FREEZE_REQ);
                unfreeze_req[r] <= (state_d[r] == ST_UNFREEZE_REQ);
                region_reset[r] <= (state_d[r] == ST_RESET) || (state_d[r] == ST_ERROR);
            end
            region_err <= (region_err & ~err_clr) | err_set;
            done_irq   <= done_set | (done_irq & ~done_clr);
            cmd_err_q  <= cmd_bad;
        end
    end

    always_comb begin
        region_state = '0;
        for (int r = 0; r < NUM_REGIONS; r++) region_state[3*r +: 3] = state_q[r];
    end

endmodule

// File: tb/tb_pr_region_sequencer.sv
// Directed self-checking bench for pr_region_sequencer (3 regions, 16-cycle reset pulse).
// Timeout scenarios run only when PR_SEQ_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8).
module tb_pr_region_sequencer;

    localparam int NUM_REGIONS    = 3;
    localparam int REGION_W       = 2;
    localparam int RESET_CYCLES   = 16;
    localparam int TIMEOUT_CYCLES = 8;

    localparam logic [1:0] OP_FREEZE   = 2'b00;
    localparam logic [1:0] OP_UNFREEZE = 2'b01;
    localparam logic [1:0] OP_CLEAR    = 2'b10;
    localparam logic [1:0] OP_RSVD     = 2'b11;

    localparam logic [2:0] S_RUN = 3'd0;
    localparam logic [2:0] S_FRQ = 3'd1;
    localparam logic [2:0] S_FRZ = 3'd2;
    localparam logic [2:0] S_RST = 3'd3;
    localparam logic [2:0] S_UFQ = 3'd4;
    localparam logic [2:0] S_ERR = 3'd5;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [NUM_REGIONS-1:0]   freeze_req;
    logic [NUM_REGIONS-1:0]   freeze_status = '0;
    logic [NUM_REGIONS-1:0]   unfreeze_req;
    logic [NUM_REGIONS-1:0]   unfreeze_status = '0;
    logic [NUM_REGIONS-1:0]   region_reset;
    logic [2*NUM_REGIONS-1:0] illegal_req = '0;
    logic [3*NUM_REGIONS-1:0] region_state;
    logic [NUM_REGIONS-1:0]   region_err;
    logic                     done_irq;

    int checks   = 0;
    int failures = 0;

    pr_region_sequencer_if #(.REGION_W(REGION_W)) cmd_bus ();

    pr_region_sequencer #(
        .NUM_REGIONS   (NUM_REGIONS),
        .REGION_W      (REGION_W),
        .RESET_CYCLES  (RESET_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd            (cmd_bus),
        .freeze_req     (freeze_req),
        .freeze_status  (freeze_status),
        .unfreeze_req   (unfreeze_req),
        .unfreeze_status(unfreeze_status),
        .region_reset   (region_reset),
        .illegal_req    (illegal_req),
        .region_state   (region_state),
        .region_err     (region_err),
        .done_irq       (done_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drives one command; returns at the falling edge of the cycle after the transfer.
    task automatic send_cmd(input logic [REGION_W-1:0] region, input logic [1:0] op);
        @(negedge clk);
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_region = region;
        cmd_bus.cmd_op     = op;
        @(posedge clk);
        @(negedge clk);
        cmd_bus.cmd_valid  = 1'b0;
    endtask

    task automatic wait_state(input string tag, input int r, input logic [2:0] st, input int max);
        int i = 0;
        while (region_state[3*r +: 3] != st && i < max) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(region_state[3*r +: 3]), 32'(st));
    endtask

`ifndef PR_SEQ_TIMEOUT_EN
    task automatic freeze_region(input int r);
        send_cmd(REGION_W'(r), OP_FREEZE);
        freeze_status[r] = 1'b1;
        @(negedge clk);
        freeze_status[r] = 1'b0;
        check("freeze_helper", 32'(region_state[3*r +: 3]), 32'(S_FRZ));
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cmd_bus.cmd_valid  = 1'b0;
        cmd_bus.cmd_region = '0;
        cmd_bus.cmd_op     = OP_FREEZE;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state",    32'(region_state), 32'd0);
        check("rst_freeze",   32'(freeze_req), 32'd0);
        check("rst_unfreeze", 32'(unfreeze_req), 32'd0);
        check("rst_rreset",   32'(region_reset), 32'd0);
        check("rst_err",      32'(region_err), 32'd0);
        check("rst_irq",      32'(done_irq), 32'd0);
        check("rst_cmd_err",  32'(cmd_bus.cmd_err), 32'd0);
        check("rst_ready",    32'(cmd_bus.cmd_ready), 32'd1);
        reset_n = 1'b1;

        // Freeze region 1, acknowledge during the fifth cycle of freeze_req
        send_cmd(2'd1, OP_FREEZE);
        check("frz_req_on", 32'(freeze_req), 32'b010);
        check("frz_state1", 32'(region_state[5:3]), 32'(S_FRQ));
        #1 check("busy_not_ready", 32'(cmd_bus.cmd_ready), 32'd0);
        cmd_bus.cmd_region = 2'd3;
        #1 check("oor_ready", 32'(cmd_bus.cmd_ready), 32'd1);
        cmd_bus.cmd_region = 2'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!freeze_req[1]) break;
            n++;
            if (n == 5) freeze_status[1] = 1'b1;
            @(negedge clk);
        end
        freeze_status[1] = 1'b0;
        check("frz_len",    32'(n), 32'd5);
        check("frz_frozen", 32'(region_state[5:3]), 32'(S_FRZ));
        check("frz_irq",    32'(done_irq), 32'd1);

        // Unfreeze region 1: timed reset then unfreeze handshake
        send_cmd(2'd1, OP_UNFREEZE);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!region_reset[1]) break;
            n++;
            @(negedge clk);
        end
        check("rst_pulse_len", 32'(n), 32'd16);
        check("ufq_req",       32'(unfreeze_req), 32'b010);
        check("ufq_state",     32'(region_state[5:3]), 32'(S_UFQ));
        unfreeze_status[1] = 1'b1;
        @(negedge clk);
        unfreeze_status[1] = 1'b0;
        check("ufq_running", 32'(region_state[5:3]), 32'(S_RUN));
        check("ufq_req_off", 32'(unfreeze_req), 32'd0);
        check("ufq_irq",     32'(done_irq), 32'd1);

        // Illegal commands: wrong state, reserved op, out-of-range index
        send_cmd(2'd0, OP_UNFREEZE);
        check("err_state_pulse", 32'(cmd_bus.cmd_err), 32'd1);
        @(negedge clk);
        check("err_state_clear", 32'(cmd_bus.cmd_err), 32'd0);
        send_cmd(2'd0, OP_RSVD);
        check("err_rsvd_pulse", 32'(cmd_bus.cmd_err), 32'd1);
        @(negedge clk);
        check("err_rsvd_clear", 32'(cmd_bus.cmd_err), 32'd0);
        send_cmd(2'd3, OP_FREEZE);
        check("err_oor_pulse", 32'(cmd_bus.cmd_err), 32'd1);
        @(negedge clk);
        check("err_oor_clear", 32'(cmd_bus.cmd_err), 32'd0);
        check("err_no_change", 32'(region_state), 32'd0);

        // illegal_req outside a handshake state is ignored
        illegal_req = 6'b111111;
        @(negedge clk);
        illegal_req = '0;
        check("ill_ignored_st",  32'(region_state), 32'd0);
        check("ill_ignored_err", 32'(region_err), 32'd0);

`ifdef PR_SEQ_TIMEOUT_EN
        // No acknowledge: ERROR after 8 cycles in FREEZE_REQ
        send_cmd(2'd0, OP_FREEZE);
        repeat (7) @(negedge clk);
        check("tmo_still_req", 32'(region_state[2:0]), 32'(S_FRQ));
        @(negedge clk);
        check("tmo_error",   32'(region_state[2:0]), 32'(S_ERR));
        check("tmo_err_bit", 32'(region_err), 32'b001);
        send_cmd(2'd0, OP_CLEAR);
        check("tmo_cleared", 32'(region_state[2:0]), 32'(S_FRZ));
        // Acknowledge on the eighth cycle wins over the timeout
        send_cmd(2'd1, OP_FREEZE);
        repeat (7) @(negedge clk);
        freeze_status[1] = 1'b1;
        @(negedge clk);
        freeze_status[1] = 1'b0;
        check("tmo_ack_frozen", 32'(region_state[5:3]), 32'(S_FRZ));
        check("tmo_ack_noerr",  32'(region_err), 32'd0);
`else
        // Without the timeout the handshake waits indefinitely
        send_cmd(2'd0, OP_FREEZE);
        repeat (40) @(negedge clk);
        check("wait_still_req", 32'(region_state[2:0]), 32'(S_FRQ));
        check("wait_req_high",  32'(freeze_req), 32'b001);
        freeze_status[0] = 1'b1;
        @(negedge clk);
        freeze_status[0] = 1'b0;
        check("wait_frozen", 32'(region_state[2:0]), 32'(S_FRZ));
`endif

        // illegal_req during FREEZE_REQ of region 2, then clear
        send_cmd(2'd2, OP_FREEZE);
        illegal_req[5:4] = 2'b01;
        @(negedge clk);
        illegal_req = '0;
        check("ill_error",  32'(region_state[8:6]), 32'(S_ERR));
        check("ill_errbit", 32'(region_err), 32'b100);
        check("ill_rreset", 32'(region_reset[2]), 32'd1);
        check("ill_nofrz",  32'(freeze_req[2]), 32'd0);
        send_cmd(2'd2, OP_FREEZE);
        check("ill_bad_op", 32'(cmd_bus.cmd_err), 32'd1);
        check("ill_stay",   32'(region_state[8:6]), 32'(S_ERR));
        send_cmd(2'd2, OP_CLEAR);
        check("clr_frozen", 32'(region_state[8:6]), 32'(S_FRZ));
        check("clr_errbit", 32'(region_err), 32'd0);
        check("clr_irq",    32'(done_irq), 32'd0);
        check("clr_rreset", 32'(region_reset[2]), 32'd0);

        // Acknowledge and illegal_req together during UNFREEZE_REQ: ERROR wins
        send_cmd(2'd0, OP_UNFREEZE);
        wait_state("win_reach_ufq", 0, S_UFQ, 40);
        unfreeze_status[0] = 1'b1;
        illegal_req[1:0]   = 2'b10;
        @(negedge clk);
        unfreeze_status[0] = 1'b0;
        illegal_req        = '0;
        check("win_error",  32'(region_state[2:0]), 32'(S_ERR));
        check("win_errbit", 32'(region_err), 32'b001);
        check("win_no_irq", 32'(done_irq), 32'd0);
        send_cmd(2'd0, OP_CLEAR);
        check("win_cleared", 32'(region_state[2:0]), 32'(S_FRZ));

        // Asynchronous reset in the middle of region 1's reset pulse
`ifndef PR_SEQ_TIMEOUT_EN
        freeze_region(1);
`endif
        send_cmd(2'd1, OP_UNFREEZE);
        repeat (4) @(negedge clk);
        check("mid_rst_pulse", 32'(region_reset), 32'b010);
        check("mid_rst_state", 32'(region_state), 32'({S_FRZ, S_RST, S_FRZ}));
        #2 reset_n = 1'b0;
        #1;
        check("arst_state",  32'(region_state), 32'd0);
        check("arst_rreset", 32'(region_reset), 32'd0);
        check("arst_freeze", 32'(freeze_req | unfreeze_req), 32'd0);
        check("arst_irq",    32'({region_err, done_irq, cmd_bus.cmd_err}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cmd_bus.cmd_region = 2'd1;
        #1 check("arst_ready", 32'(cmd_bus.cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pr_region_sequencer.md
Name: pr_region_sequencer

Overview:
- Parametrised freeze/reset/unfreeze sequencer for NUM_REGIONS partial-reconfiguration regions.
- Sits between the host control path (Nios/JTAG command master) and the per-region PR freeze controllers. Each region gets its own handshake FSM, so software issues one command instead of toggling raw PIO bits.
- Adds hold-until-acknowledge handshakes, a timed reset pulse, illegal-request trapping, per-region error latching and a completion interrupt.

Parameters:
- NUM_REGIONS, 3, number of PR regions / controller channels (1..16).
- REGION_W, 2, width of cmd_region; must satisfy 2**REGION_W >= NUM_REGIONS.
- RESET_CYCLES, 16, width of the region_reset pulse in clk cycles (>=1).
- TIMEOUT_CYCLES, 1024, handshake timeout in cycles (>=2); used only with PR_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command accept; transfer occurs when cmd_valid && cmd_ready
- cmd_region  in  REGION_W  target region index
- cmd_op  in  2  00 freeze, 01 unfreeze, 10 clear error, 11 reserved
- cmd_err  out  1  one-cycle pulse: accepted command was illegal for the target state or index
- freeze_req  out  NUM_REGIONS  per-region freeze request
- freeze_status  in  NUM_REGIONS  per-region freeze acknowledge
- unfreeze_req  out  NUM_REGIONS  per-region unfreeze request
- unfreeze_status  in  NUM_REGIONS  per-region unfreeze acknowledge
- region_reset  out  NUM_REGIONS  active-high reset to region logic
- illegal_req  in  2*NUM_REGIONS  controller illegal-request flags, 2 bits per region
- region_state  out  3*NUM_REGIONS  current FSM state per region
- region_err  out  NUM_REGIONS  sticky error per region
- done_irq  out  1  level interrupt; set on any completed sequence, cleared by clear-error op or reset

Behaviour:
- Reset (asynchronous): all FSMs enter RUNNING. All outputs are 0, including done_irq and region_err; cmd_ready follows its combinational definition.
- State encoding: RUNNING=0, FREEZE_REQ=1, FROZEN=2, RESET=3, UNFREEZE_REQ=4, ERROR=5.
- Output decode is registered from state:
  - freeze_req=1 only in FREEZE_REQ.
  - unfreeze_req=1 only in UNFREEZE_REQ.
  - region_reset=1 in RESET and ERROR.
- cmd_ready: combinational. It is 0 when cmd_region >= NUM_REGIONS is not the cause, i.e. cmd_ready = 1 unless the target region is in FREEZE_REQ, RESET or UNFREEZE_REQ. An out-of-range index is accepted and flagged.
- Command rules (at the accept cycle T):
  - freeze: RUNNING -> FREEZE_REQ at T+1.
  - unfreeze: FROZEN -> RESET at T+1.
  - clear: ERROR -> FROZEN; also clears region_err[r] and done_irq.
  - Any other op/state combination, a reserved op, or an out-of-range index: no state change, cmd_err=1 at T+1.
- FREEZE_REQ: on freeze_status[r]=1 sampled at cycle S, go to FROZEN at S+1 (freeze_req low at S+1) and set done_irq.
- RESET: a counter loads on entry; region_reset stays high for exactly RESET_CYCLES cycles, then the FSM enters UNFREEZE_REQ.
- UNFREEZE_REQ: on unfreeze_status[r]=1, go to RUNNING next cycle and set done_irq.
- ERROR entry: illegal_req[2r+1:2r] != 0 while in FREEZE_REQ or UNFREEZE_REQ -> ERROR next cycle; region_err[r] set. Any illegal_req in other states is ignored.
- Simultaneous events:
  - Acknowledge and illegal_req in the same cycle: ERROR wins.
  - Acknowledge and timeout in the same cycle: acknowledge wins.
- ERROR is exited only by the clear op. The region is then treated as FROZEN and recovers via unfreeze.
- Regions are independent. Only one command is accepted per cycle; the other FSMs keep running.
- region_state[3r+2:3r] reflects the current state register with no added latency.

Optional Feature:
- Macro PR_SEQ_TIMEOUT_EN.
- Defined:
  - Each region has a timeout counter, cleared on entry to FREEZE_REQ or UNFREEZE_REQ.
  - If the acknowledge is still absent after TIMEOUT_CYCLES cycles in that state, the FSM enters ERROR on the following cycle and region_err is set.
- Undefined: no counters are instantiated and handshakes wait indefinitely; TIMEOUT_CYCLES is ignored.

Test Plan:
- Freeze region 1: freeze_status[1] raised 5 cycles after freeze_req[1] -> freeze_req[1] high for exactly 5 cycles; region_state[5:3]=2; done_irq=1.
- Unfreeze region 1 with RESET_CYCLES=16 -> region_reset[1] high exactly 16 cycles; unfreeze_req[1] follows; state returns to 0 one cycle after unfreeze_status[1].
- Unfreeze on a RUNNING region 0, then op=11, then region index 3 -> cmd_err pulses once per command; no state change in any region.
- illegal_req[5:4]=2'b01 during FREEZE_REQ of region 2 -> ERROR, region_err[2]=1, region_reset[2]=1; clear op -> FROZEN, region_err[2]=0.
- With PR_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8: freeze region 0 with no acknowledge -> ERROR after 8 cycles. Separately, acknowledge on cycle 8 -> FROZEN, no error.
- Assert reset_n low mid-RESET on region 1 -> all outputs 0 immediately and all regions RUNNING; after release, cmd_ready=1.
